// File: rtl/frame_ctrl.sv
// frame_ctrl: frame sequencer for the capture pipeline; optional watchdog via FRAME_CTRL_WDOG_EN
module frame_ctrl #(
  parameter int EXP_PIX  = 307200,
  parameter int FRAMES   = 0,
  parameter int CNT_W    = 19,
  parameter int WDOG_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        start,
  input  logic        stop,
  input  logic        clr_err,
  input  logic        vsync,
  input  logic        tail_vld,
  input  logic        tail_sop,
  input  logic        tail_eop,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        en_capture,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic        err,
  output logic [1:0]  err_code
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_RUN, S_DRAIN, S_ERR} state_t;
  state_t            r_state, w_next;
  logic              r_vsync_d, r_stop_req;
  logic [CNT_W-1:0]  r_pix_cnt, w_pix_inc;
  logic [15:0]       w_frame_nxt;
  logic [1:0]        w_code_nxt;
  logic              w_done_nxt, w_vs_rise, w_ovf, w_eop, w_match, w_last, w_wdog_hit;
  assign w_vs_rise = vsync & ~r_vsync_d;
  assign w_ovf     = fifo_full & tail_vld & (r_state inside {S_WAIT_VS, S_RUN, S_DRAIN});
  assign w_pix_inc = tail_sop ? CNT_W'(1) : (&r_pix_cnt ? r_pix_cnt : r_pix_cnt + CNT_W'(1));
  assign w_eop     = (r_state == S_RUN) & tail_vld & tail_eop;
  assign w_match   = w_pix_inc == CNT_W'(EXP_PIX);
  assign w_last    = (FRAMES != 0) && ((frame_cnt + 16'd1) == 16'(FRAMES));
`ifdef FRAME_CTRL_WDOG_EN
  logic [31:0] r_wdog;
  assign w_wdog_hit = r_wdog >= 32'(WDOG_CYC - 1);
  // watchdog restarts on every state change and on each tail beat while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wdog <= '0;
    else r_wdog <= (w_next != r_state || (r_state == S_RUN && tail_vld)) ? '0 : r_wdog + 32'd1;
`else
  assign w_wdog_hit = 1'b0;
`endif
  // next-state and next-output decode; overflow outranks every other event
  always_comb begin
    w_next      = r_state;
    w_frame_nxt = frame_cnt;
    w_code_nxt  = err_code;
    w_done_nxt  = 1'b0;
    if (w_ovf) begin
      w_next     = S_ERR;
      w_code_nxt = 2'd1;
    end else begin
      case (r_state)
        S_IDLE: if (start && cfg_done) begin
          w_next      = S_WAIT_VS;
          w_frame_nxt = '0;
        end
        S_WAIT_VS: if (stop) w_next = S_IDLE;
          else if (w_vs_rise) w_next = S_RUN;
          else if (w_wdog_hit) begin
            w_next     = S_ERR;
            w_code_nxt = 2'd3;
          end
        S_RUN: if (w_eop) begin
            if (!w_match) begin
              w_next     = S_ERR;
              w_code_nxt = 2'd2;
            end else begin
              w_frame_nxt = frame_cnt + 16'd1;
              if (r_stop_req || stop || w_last) w_next = S_DRAIN;
            end
          end else if (!tail_vld && w_wdog_hit) begin
            w_next     = S_ERR;
            w_code_nxt = 2'd3;
          end
        S_DRAIN: if (fifo_empty) begin
          w_next     = S_IDLE;
          w_done_nxt = 1'b1;
        end
        S_ERR: if (clr_err) begin
          w_next     = S_IDLE;
          w_code_nxt = 2'd0;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end
  // state, pixel counter, stop request and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vsync_d  <= 1'b0;
      r_stop_req <= 1'b0;
      r_pix_cnt  <= '0;
      en_capture <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      r_state    <= w_next;
      r_vsync_d  <= vsync;
      r_stop_req <= (r_state == S_IDLE) ? 1'b0 : (r_stop_req | (stop & (r_state == S_RUN)));
      if (r_state == S_RUN && tail_vld) r_pix_cnt <= w_pix_inc;
      en_capture <= w_next == S_RUN;
      busy       <= w_next != S_IDLE;
      done       <= w_done_nxt;
      frame_cnt  <= w_frame_nxt;
      err        <= w_next == S_ERR;
      err_code   <= w_code_nxt;
    end
endmodule

// File: tb/tb_frame_ctrl.sv
// tb_frame_ctrl: scoreboard bench for frame_ctrl (FRAMES=2 instance a, FRAMES=0 instance b)
module tb_frame_ctrl;
  logic clk = 0, rst_n = 0;
  logic cfg_done = 0, start_a = 0, start_b = 0, stop = 0, clr_err = 0, vsync = 0;
  logic tail_vld = 0, tail_sop = 0, tail_eop = 0, fifo_full = 0, fifo_empty = 0;
  logic a_en, a_busy, a_done, a_err, b_en, b_busy, b_done, b_err;
  logic [15:0] a_fc, b_fc;
  logic [1:0] a_code, b_code;
  logic a_err_q = 0, b_err_q = 0;
  int checks = 0, errors = 0;
  typedef struct {int dut; int kind; int val;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  frame_ctrl #(.EXP_PIX(16), .FRAMES(2), .CNT_W(5), .WDOG_CYC(100)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .start(start_a), .stop(stop), .clr_err(clr_err),
    .vsync(vsync), .tail_vld(tail_vld), .tail_sop(tail_sop), .tail_eop(tail_eop),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .en_capture(a_en), .busy(a_busy),
    .done(a_done), .frame_cnt(a_fc), .err(a_err), .err_code(a_code));
  frame_ctrl #(.EXP_PIX(16), .FRAMES(0), .CNT_W(5), .WDOG_CYC(100)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .start(start_b), .stop(stop), .clr_err(clr_err),
    .vsync(vsync), .tail_vld(tail_vld), .tail_sop(tail_sop), .tail_eop(tail_eop),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .en_capture(b_en), .busy(b_busy),
    .done(b_done), .frame_cnt(b_fc), .err(b_err), .err_code(b_code));
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic ev(int d, int k, int v);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got dut%0d kind%0d val%0d expected none", d, k, v);
    end else begin
      e = q.pop_front();
      chk($sformatf("event_dut%0d_kind%0d", e.dut, e.kind), d * 100 + k * 10 + v, e.dut * 100 + e.kind * 10 + e.val);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (a_done) ev(0, 0, int'(a_fc));
    if (a_err && !a_err_q) ev(0, 1, int'(a_code));
    if (b_done) ev(1, 0, int'(b_fc));
    if (b_err && !b_err_q) ev(1, 1, int'(b_code));
    a_err_q = a_err;
    b_err_q = b_err;
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(int d, int k, int v);
    exp_t e;
    e.dut = d; e.kind = k; e.val = v;
    q.push_back(e);
  endtask
  task automatic vs_pulse();
    vsync = 1;
    tick();
    vsync = 0;
    tick();
  endtask
  task automatic frame(int n, int stop_at, int full_at);
    for (int i = 1; i <= n; i++) begin
      tail_vld = 1; tail_sop = (i == 1); tail_eop = (i == n);
      stop = (i == stop_at); fifo_full = (i == full_at);
      tick();
    end
    tail_vld = 0; tail_sop = 0; tail_eop = 0; stop = 0; fifo_full = 0;
    tick();
  endtask
  task automatic go_a();
    start_a = 1;
    tick();
    start_a = 0;
    vs_pulse();
  endtask
  task automatic clear();
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("clr_err", int'(a_err), 0);
    chk("clr_code", int'(a_code), 0);
    chk("clr_busy", int'(a_busy), 0);
  endtask
  initial begin
    tick(2);
    chk("rst_en", int'(a_en), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_fc", int'(a_fc), 0);
    chk("rst_err", int'({a_err, a_code, a_done}), 0);
    rst_n = 1;
    tick();
    start_a = 1;
    tick();
    start_a = 0;
    tick();
    chk("nocfg_busy", int'(a_busy), 0);
    cfg_done = 1;
    start_a = 1;
    tick();
    start_a = 0;
    chk("wait_busy", int'(a_busy), 1);
    tick(3);
    chk("wait_en", int'(a_en), 0);
    vsync = 1;
    tick();
    vsync = 0;
    chk("vs_en", int'(a_en), 1);
    tick();
    frame(16, 0, 0);
    chk("f1_fc", int'(a_fc), 1);
    chk("f1_en", int'(a_en), 1);
    push(0, 0, 2);
    frame(16, 0, 0);
    chk("drain_fc", int'(a_fc), 2);
    chk("drain_en", int'(a_en), 0);
    tick(2);
    chk("drain_hold", int'({a_busy, a_done}), 2);
    fifo_empty = 1;
    tick();
    chk("done_pulse", int'({a_busy, a_done}), 1);
    tick();
    chk("done_once", int'(a_done), 0);
    fifo_empty = 0;
    start_b = 1;
    tick();
    start_b = 0;
    vs_pulse();
    frame(16, 0, 0);
    frame(16, 0, 0);
    chk("cont_fc", int'(b_fc), 2);
    chk("cont_en", int'(b_en), 1);
    push(1, 0, 3);
    tail_vld = 0;
    frame(16, 5, 0);
    chk("stop_fc", int'(b_fc), 3);
    chk("stop_en", int'(b_en), 0);
    fifo_empty = 1;
    tick(2);
    fifo_empty = 0;
    chk("stop_idle", int'(b_busy), 0);
    go_a();
    push(0, 1, 2);
    frame(15, 0, 0);
    chk("len_err", int'({a_err, a_code, a_en}), 3'b110 * 2);
    clear();
    go_a();
    push(0, 1, 1);
    frame(16, 0, 4);
    chk("ovf_code", int'(a_code), 1);
    clear();
    go_a();
    push(0, 1, 1);
    frame(15, 0, 15);
    chk("ovf_prio", int'(a_code), 1);
    clear();
    start_a = 1;
    tick();
    start_a = 0;
`ifdef FRAME_CTRL_WDOG_EN
    push(0, 1, 3);
    tick(110);
    chk("wdog_code", int'(a_code), 3);
    clear();
`else
    tick(1000);
    chk("nowdog_wait", int'({a_busy, a_en, a_err}), 4);
    stop = 1;
    tick();
    stop = 0;
    tick();
    chk("wait_stop", int'({a_busy, a_done}), 0);
`endif
    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
